// File: rtl/ifu_inst_queue_pkg.sv
// Shared constants for the IFU instruction queue slice.
package ifu_inst_queue_pkg;

   localparam int unsigned CPU_WIDTH      = 32;
   localparam int unsigned AXI_RESP_WIDTH = 2;
   localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY = '0;

endpackage

// File: rtl/ifu_inst_queue_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and a synchronous clear.
module sync_fifo_fwft #(
   parameter int unsigned W     = 65,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     din_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o,
   output logic [W-1:0]     dout_o
);

   logic [W-1:0]   mem_q [DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

   assign do_pop  = pop_i & ~empty_o;
   // A push into a full queue is only accepted when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer next-state; clear wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !clr_i) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/ifu_inst_queue.sv
// IFU instruction queue: fetch-slot reservation, stale-response dropping and protocol error flag.
module ifu_inst_queue
   import ifu_inst_queue_pkg::*;
#(
   parameter int unsigned DW    = CPU_WIDTH,
   parameter int unsigned AW    = CPU_WIDTH,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           req_fire,
   output logic           can_req,
   input  logic           rsp_valid,
   input  logic [AW-1:0]  rsp_pc,
   input  logic [DW-1:0]  rsp_inst,
   input  logic           rsp_err,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [AW-1:0]  out_pc,
   output logic [DW-1:0]  out_inst,
   output logic           out_err,
   output logic [PTR_W:0] count,
   output logic           proto_err
);

   localparam int unsigned EW = AW + DW + 1;

   logic [PTR_W:0]   out_cnt_q, out_cnt_d;
   logic [PTR_W:0]   drop_cnt_q, drop_cnt_d;
   logic             proto_err_q, proto_err_d;
   logic             fifo_full, fifo_empty;
   logic [EW-1:0]    head;
   logic             rsp_acc, rsp_keep, pop;
   logic [PTR_W+1:0] occupancy;

   assign rsp_acc  = rsp_valid & (out_cnt_q != '0);
   assign rsp_keep = rsp_acc & (drop_cnt_q == '0) & ~flush;
   assign pop      = out_valid & out_ready;

   sync_fifo_fwft #(
      .W     (EW),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush),
      .push_i  (rsp_keep),
      .pop_i   (pop),
      .din_i   ({rsp_pc, rsp_inst, rsp_err}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count),
      .dout_o  (head)
   );

   assign out_valid                  = ~fifo_empty;
   assign {out_pc, out_inst, out_err} = head;

   assign occupancy = {1'b0, count} + {1'b0, out_cnt_q};
   assign can_req   = ~flush & (occupancy < (PTR_W+2)'(DEPTH));
   assign proto_err = proto_err_q;

   // Outstanding/drop accounting and sticky error next-state.
   always_comb begin
      out_cnt_d   = out_cnt_q + (PTR_W+1)'(req_fire) - (PTR_W+1)'(rsp_acc);
      drop_cnt_d  = drop_cnt_q;
      proto_err_d = proto_err_q;
      if (flush) begin
         // out_cnt already includes fetches pending drop, so every outstanding
         // fetch not answered this cycle becomes a drop (back-to-back safe).
         drop_cnt_d = out_cnt_q - (PTR_W+1)'(rsp_acc);
      end else if (rsp_acc && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - (PTR_W+1)'(1);
      end
      if ((rsp_valid && (out_cnt_q == '0)) || (rsp_keep && fifo_full && !pop))
         proto_err_d = 1'b1;
   end

   // Accounting registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         out_cnt_q   <= out_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule
